// File: rtl/hada_pack_stream.sv
// rtl/hada_pack_stream.sv - packs 64-bit elements into 8/16/32/64-bit lanes of a 64-bit word
// Optional macro HADA_PACK_SAT_EN: saturate overflowed lanes instead of truncating them.
module hada_pack_stream (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  mode,
    input  logic        is_signed,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic [3:0]  out_count,
    output logic        out_ovf
);

    typedef enum logic [1:0] {EMPTY, FILL, HOLD} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  mode_q, mode_d;
    logic        sgn_q, sgn_d;
    logic [63:0] data_q, data_d;
    logic        ovf_q, ovf_d;

    logic        accept;
    logic [1:0]  eff_mode;
    logic        eff_sgn;
    logic [3:0]  lanes;
    logic [5:0]  shamt;
    logic [63:0] sext, zext, lane_val, placed;
    logic        lane_ovf;
`ifdef HADA_PACK_SAT_EN
    logic [63:0] sat_val;
`endif

    assign out_valid = (state_q == HOLD);
    assign in_ready  = !out_valid;
    assign out_data  = data_q;
    assign out_count = cnt_q;
    assign out_ovf   = ovf_q;

    assign accept = in_valid && in_ready;

    // The first element of a word uses the live mode/sign; later ones use the latched copy.
    assign eff_mode = (state_q == EMPTY) ? mode : mode_q;
    assign eff_sgn  = (state_q == EMPTY) ? is_signed : sgn_q;
    assign lanes    = 4'd8 >> eff_mode;
    assign shamt    = 6'({cnt_q[2:0], 3'b000} << eff_mode);

    always_comb begin
        sext = in_data;
        zext = in_data;
        case (eff_mode)
            2'b00: begin
                sext = {{56{in_data[7]}}, in_data[7:0]};
                zext = {56'd0, in_data[7:0]};
            end
            2'b01: begin
                sext = {{48{in_data[15]}}, in_data[15:0]};
                zext = {48'd0, in_data[15:0]};
            end
            2'b10: begin
                sext = {{32{in_data[31]}}, in_data[31:0]};
                zext = {32'd0, in_data[31:0]};
            end
            default: begin
                sext = in_data;
                zext = in_data;
            end
        endcase
        // At 64 bits both extensions equal in_data, so the flag is naturally 0.
        lane_ovf = eff_sgn ? (sext != in_data) : (zext != in_data);
        lane_val = zext;
`ifdef HADA_PACK_SAT_EN
        case (eff_mode)
            2'b00:   sat_val = eff_sgn ? (in_data[63] ? 64'h80 : 64'h7F) : 64'hFF;
            2'b01:   sat_val = eff_sgn ? (in_data[63] ? 64'h8000 : 64'h7FFF) : 64'hFFFF;
            2'b10:   sat_val = eff_sgn ? (in_data[63] ? 64'h8000_0000 : 64'h7FFF_FFFF)
                                       : 64'hFFFF_FFFF;
            default: sat_val = in_data;
        endcase
        if (lane_ovf) begin
            lane_val = sat_val;
        end
`endif
        placed = lane_val << shamt;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        sgn_d   = sgn_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    mode_d  = mode;
                    sgn_d   = is_signed;
                    data_d  = placed;
                    ovf_d   = lane_ovf;
                    cnt_d   = 4'd1;
                    // A flush arriving with an element closes the word around it.
                    state_d = (lanes == 4'd1 || flush) ? HOLD : FILL;
                end
            end
            FILL: begin
                if (accept) begin
                    data_d  = data_q | placed;
                    ovf_d   = ovf_q | lane_ovf;
                    cnt_d   = cnt_q + 4'd1;
                    state_d = ((cnt_q + 4'd1) == lanes || flush) ? HOLD : FILL;
                end else if (flush) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = EMPTY;
                    cnt_d   = 4'd0;
                    data_d  = 64'd0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = EMPTY;
                cnt_d   = 4'd0;
                data_d  = 64'd0;
                ovf_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            cnt_q   <= 4'd0;
            mode_q  <= 2'b00;
            sgn_q   <= 1'b0;
            data_q  <= 64'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            sgn_q   <= sgn_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_hada_pack_stream.sv
// tb/tb_hada_pack_stream.sv - directed self-checking bench for hada_pack_stream
`timescale 1ns/1ps
module tb_hada_pack_stream;

    logic        clk;
    logic        rst_n;
    logic [1:0]  mode;
    logic        is_signed;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [3:0]  out_count;
    logic        out_ovf;

    int vectors;
    int miscompares;

    logic [63:0] w_data;
    logic [3:0]  w_count;
    logic        w_ovf;
    logic        w_got;

    hada_pack_stream dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .is_signed(is_signed),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .out_ovf(out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] d, input logic fl);
        logic done;
        done      = 1'b0;
        in_valid  = 1'b1;
        in_data   = d;
        flush     = fl;
        for (int i = 0; i < 20 && !done; i++) begin
            if (in_ready) done = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        in_data  = 64'hDEAD_BEEF_DEAD_BEEF;
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: in_ready never high, required accept of %h", d);
        end
    endtask

    task automatic get_word();
        w_got = 1'b0;
        for (int i = 0; i < 20 && !w_got; i++) begin
            if (out_valid) begin
                w_got   = 1'b1;
                w_data  = out_data;
                w_count = out_count;
                w_ovf   = out_ovf;
            end
            tick();
        end
        vectors++;
        if (w_got !== 1'b1) begin
            miscompares++;
            $display("FAIL word_timeout: out_valid=%b, required 1", w_got);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        vectors += 5;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
        if (out_data !== 64'd0) begin miscompares++; $display("FAIL rst_out_data: got %h, required 0", out_data); end
        if (out_count !== 4'd0) begin miscompares++; $display("FAIL rst_out_count: got %0d, required 0", out_count); end
        if (out_ovf !== 1'b0)   begin miscompares++; $display("FAIL rst_out_ovf: got %b, required 0", out_ovf); end
        if (in_ready !== 1'b1)  begin miscompares++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_bytes();
        mode = 2'b00; is_signed = 1'b1;
        for (int i = 1; i <= 8; i++) send(64'(i), 1'b0);
        get_word();
        vectors += 3;
        if (w_data !== 64'h0807060504030201) begin miscompares++; $display("FAIL bytes_data: got %h, required 0807060504030201", w_data); end
        if (w_count !== 4'd8) begin miscompares++; $display("FAIL bytes_count: got %0d, required 8", w_count); end
        if (w_ovf !== 1'b0)   begin miscompares++; $display("FAIL bytes_ovf: got %b, required 0", w_ovf); end
    endtask

    task automatic test_ovf16();
        logic [63:0] exp;
`ifdef HADA_PACK_SAT_EN
        exp = 64'h0000_0000_7FFF_FFFF;
`else
        exp = 64'h0000_0000_2345_FFFF;
`endif
        mode = 2'b01; is_signed = 1'b1;
        send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        send(64'h0000_0000_0001_2345, 1'b1);
        get_word();
        vectors += 3;
        if (w_data !== exp)   begin miscompares++; $display("FAIL ovf16_data: got %h, required %h", w_data, exp); end
        if (w_count !== 4'd2) begin miscompares++; $display("FAIL ovf16_count: got %0d, required 2", w_count); end
        if (w_ovf !== 1'b1)   begin miscompares++; $display("FAIL ovf16_ovf: got %b, required 1", w_ovf); end
    endtask

    task automatic test_flush32();
        mode = 2'b10; is_signed = 1'b1;
        flush = 1'b1;
        tick(); tick();
        flush = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_empty: out_valid=%b, required 0", out_valid); end
        send(64'h1111_1111, 1'b0);
        send(64'h2222_2222, 1'b0);
        get_word();
        vectors += 2;
        if (w_data !== 64'h2222_2222_1111_1111) begin miscompares++; $display("FAIL flush32_w1: got %h, required 2222222211111111", w_data); end
        if (w_count !== 4'd2) begin miscompares++; $display("FAIL flush32_w1_count: got %0d, required 2", w_count); end
        send(64'h3333_3333, 1'b1);
        get_word();
        vectors += 2;
        if (w_data !== 64'h0000_0000_3333_3333) begin miscompares++; $display("FAIL flush32_w2: got %h, required 0000000033333333", w_data); end
        if (w_count !== 4'd1) begin miscompares++; $display("FAIL flush32_w2_count: got %0d, required 1", w_count); end
    endtask

    task automatic test_hold();
        mode = 2'b00; is_signed = 1'b0;
        for (int i = 0; i < 7; i++) send(64'(8'h10 + i), 1'b0);
        out_ready = 1'b0;
        send(64'h17, 1'b0);
        for (int c = 0; c < 5; c++) begin
            vectors += 3;
            if (out_valid !== 1'b1) begin miscompares++; $display("FAIL hold_valid c%0d: got %b, required 1", c, out_valid); end
            if (in_ready !== 1'b0)  begin miscompares++; $display("FAIL hold_in_ready c%0d: got %b, required 0", c, in_ready); end
            if (out_data !== 64'h1716151413121110) begin
                miscompares++; $display("FAIL hold_data c%0d: got %h, required 1716151413121110", c, out_data);
            end
            if (c < 4) tick();
        end
        out_ready = 1'b1;
        tick();
        vectors += 2;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL hold_release: out_valid=%b, required 0", out_valid); end
        if (in_ready !== 1'b1)  begin miscompares++; $display("FAIL hold_release_ready: got %b, required 1", in_ready); end
    endtask

    task automatic test_u64();
        mode = 2'b11; is_signed = 1'b0;
        send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        get_word();
        vectors += 3;
        if (w_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin miscompares++; $display("FAIL u64_data: got %h, required ffffffffffffffff", w_data); end
        if (w_count !== 4'd1) begin miscompares++; $display("FAIL u64_count: got %0d, required 1", w_count); end
        if (w_ovf !== 1'b0)   begin miscompares++; $display("FAIL u64_ovf: got %b, required 0", w_ovf); end
    endtask

    task automatic test_mode_change();
        mode = 2'b00; is_signed = 1'b0;
        send(64'h05, 1'b0);
        mode = 2'b11; is_signed = 1'b1;
        send(64'h1FF, 1'b1);
        get_word();
        vectors += 3;
        if (w_data !== 64'hFF05) begin miscompares++; $display("FAIL modechg_data: got %h, required 000000000000ff05", w_data); end
        if (w_count !== 4'd2)    begin miscompares++; $display("FAIL modechg_count: got %0d, required 2", w_count); end
        if (w_ovf !== 1'b1)      begin miscompares++; $display("FAIL modechg_ovf: got %b, required 1", w_ovf); end
    endtask

    task automatic test_reset_mid();
        mode = 2'b00; is_signed = 1'b1;
        for (int i = 0; i < 3; i++) send(64'(8'hA1 + i), 1'b0);
        #2 rst_n = 1'b0;
        #1;
        vectors += 2;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_valid: got %b, required 0", out_valid); end
        if (out_count !== 4'd0) begin miscompares++; $display("FAIL rstmid_count: got %0d, required 0", out_count); end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) send(64'(8'h31 + i), 1'b0);
        get_word();
        vectors += 2;
        if (w_data !== 64'h3837363534333231) begin miscompares++; $display("FAIL rstmid_data: got %h, required 3837363534333231", w_data); end
        if (w_count !== 4'd8) begin miscompares++; $display("FAIL rstmid_word_count: got %0d, required 8", w_count); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        mode        = 2'b00;
        is_signed   = 1'b0;
        in_valid    = 1'b0;
        in_data     = 64'd0;
        flush       = 1'b0;
        out_ready   = 1'b1;
        #1;
        test_reset();
        test_bytes();
        test_ovf16();
        test_flush32();
        test_hold();
        test_u64();
        test_mode_change();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hada_pack_stream.md
HADA_PACK_STREAM -- requirements
Module: hada_pack_stream

Interface
REQ-001 SHALL have no parameters; the lane width is selected at run time by the mode input.
REQ-002 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port mode, input, 2 bits: lane width select; 00=8, 01=16, 10=32, 11=64.
REQ-005 SHALL have port is_signed, input, 1 bit: 1 = signed (longint) source, 0 = unsigned (ulongint) source.
REQ-006 SHALL have port in_valid, input, 1 bit: source element valid.
REQ-007 SHALL have port in_ready, output, 1 bit: element accepted when in_valid and in_ready are both high.
REQ-008 SHALL have port in_data, input, 64 bits: 64-bit source element.
REQ-009 SHALL have port flush, input, 1 bit: emit the partial word.
REQ-010 SHALL have port out_valid, output, 1 bit: packed word valid.
REQ-011 SHALL have port out_ready, input, 1 bit: sink accepts the packed word.
REQ-012 SHALL have port out_data, output, 64 bits: packed word.
REQ-013 SHALL have port out_count, output, 4 bits: number of filled lanes, 1..8.
REQ-014 SHALL have port out_ovf, output, 1 bit: at least one lane in the word overflowed its width.

Function
REQ-015 Lane count SHALL be 8/4/2/1 for widths 8/16/32/64; element n of a word SHALL occupy out_data[n*W +: W], with the first accepted element in lane 0.
REQ-016 Narrowing SHALL be two's-complement truncation to W bits, matching consI8..consI64 / consW8..consW64 semantics.
REQ-017 A lane SHALL be flagged as overflowed when sign-extending (is_signed=1) or zero-extending (is_signed=0) it back to 64 bits does not equal in_data; out_ovf SHALL be the OR of the lane flags in the word; for W=64 the flag SHALL always be 0.
REQ-018 States SHALL be EMPTY (lane counter 0, out_valid=0), FILL (counter 1..lanes-1), and HOLD (out_valid=1).
REQ-019 in_ready SHALL equal !out_valid.
REQ-020 On acceptance of the last lane, the block SHALL enter HOLD, with out_valid high on the next cycle.
REQ-021 out_data, out_count, and out_ovf SHALL be stable while out_valid=1 and out_ready=0.
REQ-022 When out_valid and out_ready are both high, the block SHALL return to EMPTY, with in_ready high on the next cycle; sustained throughput is one word per lanes+1 cycles.
REQ-023 When flush=1 in FILL, the block SHALL enter HOLD with out_count equal to the filled lanes and unused lanes zero.
REQ-024 flush in EMPTY or HOLD SHALL be ignored.
REQ-025 When an element is accepted in the same cycle as flush, that element SHALL be included before the word is emitted.
REQ-026 mode and is_signed SHALL be sampled only on acceptance while in EMPTY, and SHALL be held for the rest of the word; changes mid-word SHALL have no effect.
REQ-027 in_data and mode SHALL be ignored when in_valid=0.

Reset
REQ-028 While rst_n=0, the block SHALL asynchronously force state to EMPTY, lane counter to 0, latched mode to 00, and latched is_signed to 0.
REQ-029 While rst_n=0, outputs SHALL be out_valid=0, out_data=0, out_count=0, out_ovf=0, and in_ready=1.
REQ-030 Reset mid-word SHALL discard partial and held data without emitting them.
REQ-031 Reset deassertion SHALL be synchronised externally; the first acceptance SHALL be possible on the first clock edge after release.

Configuration
REQ-032 Macro HADA_PACK_SAT_EN SHALL select saturation versus truncation.
REQ-033 When HADA_PACK_SAT_EN is defined, an overflowed lane SHALL saturate: signed to 2^(W-1)-1 or -2^(W-1); unsigned to 2^W-1.
REQ-034 out_ovf SHALL still report overflow when HADA_PACK_SAT_EN is defined.
REQ-035 When HADA_PACK_SAT_EN is undefined, lanes SHALL be truncated per REQ-016, and the saturation logic SHALL be absent from the netlist.

Verification
REQ-036 Scenario, mode=00, signed: inputs 1,2,...,8 -> one word 0x0807060504030201, out_count=8, out_ovf=0.
REQ-037 Scenario, mode=01, signed: inputs -1, 0x12345 -> without the macro, lanes 0xFFFF and 0x2345 with out_ovf=1; with HADA_PACK_SAT_EN, lane 1 is 0x7FFF.
REQ-038 Scenario, mode=10: three inputs, then flush on the third -> word 1 with two lanes, then word 2 with out_count=1 and upper 32 bits zero.
REQ-039 Scenario, out_ready held low for 5 cycles in HOLD -> out_data stable and in_ready=0 throughout; the word is accepted in the 6th cycle.
REQ-040 Scenario, mode=11, unsigned: input 0xFFFFFFFFFFFFFFFF -> word equals input, out_count=1, out_ovf=0.
REQ-041 Scenario, rst_n pulsed low after 3 of 8 byte lanes -> no word emitted, then 8 fresh inputs produce one word that contains only the new data.
